// File: rtl/inert_pkg.sv
// Shared types and constants for the inertial sensor interface.
// Optional build macro: INT_TIMEOUT_EN (IDLE watchdog that reconfigures the sensor).
package inert_pkg;

    // Interface controller states.
    typedef enum logic [3:0] {
        PWR_WAIT,
        CFG0,
        CFG1,
        CFG2,
        CFG3,
        IDLE,
        RD0,
        RD1,
        RD2,
        RD3,
        UPDATE
    } inert_state_t;

    // Configuration words written after power-up.
    localparam logic [15:0] CFG_INT = 16'h0D02;  // INT pin on data ready
    localparam logic [15:0] CFG_ACC = 16'h1053;  // accel 208 Hz
    localparam logic [15:0] CFG_GYR = 16'h1150;  // gyro 208 Hz
    localparam logic [15:0] CFG_RND = 16'h1460;  // rounding

    // Read command bytes (bit 7 set = read).
    localparam logic [7:0] RD_RTL = 8'hA2;  // pitch rate low
    localparam logic [7:0] RD_RTH = 8'hA3;  // pitch rate high
    localparam logic [7:0] RD_PTL = 8'hA4;  // pitch low
    localparam logic [7:0] RD_PTH = 8'hA5;  // pitch high

    // Timer widths: full and fast_sim variants.
    localparam int PWR_W      = 16;
    localparam int PWR_W_FAST = 10;
    localparam int WD_W       = 17;
    localparam int WD_W_FAST  = 11;

    // A read frame is the command byte followed by a don't-care byte.
    function automatic logic [15:0] rd_cmd(input logic [7:0] reg_byte);
        return {reg_byte, 8'h00};
    endfunction

endpackage

// File: rtl/inert_intf_spi.sv
// SPI_mnrch: 16-bit SPI initiator, mode 3, MSB first, SCLK = clk/16.
// SS_n falls one clk after an accepted wrt; done pulses with SS_n rising.
module SPI_mnrch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] wt_data,
    input  logic        MISO,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI
);

    logic        busy;
    logic        first_fall;  // first SCLK fall only presents the MSB, no shift
    logic        miso_smpl;   // MISO captured at the SCLK rise
    logic [3:0]  div;         // SCLK phase: 0..7 high, 8..15 low
    logic [4:0]  rise_cnt;
    logic [15:0] shft;        // transmit word shifting out, received word shifting in

    // Frame sequencer: SCLK generation, sampling on rise, shifting on fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            SS_n       <= 1'b1;
            SCLK       <= 1'b1;
            div        <= 4'd0;
            rise_cnt   <= 5'd0;
            shft       <= 16'h0000;
            first_fall <= 1'b0;
            miso_smpl  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                // wrt is only honoured while idle; a wrt during a frame is dropped.
                if (wrt) begin
                    busy       <= 1'b1;
                    SS_n       <= 1'b0;
                    SCLK       <= 1'b1;
                    div        <= 4'd0;
                    rise_cnt   <= 5'd0;
                    shft       <= wt_data;
                    first_fall <= 1'b1;
                end
            end else begin
                div <= div + 4'd1;
                if (rise_cnt == 5'd16) begin
                    // Back porch: fold in the last sample and close the frame.
                    if (div == 4'd3) begin
                        shft <= {shft[14:0], miso_smpl};
                        busy <= 1'b0;
                        SS_n <= 1'b1;
                        done <= 1'b1;
                    end
                end else if (div == 4'd7) begin
                    SCLK       <= 1'b0;
                    first_fall <= 1'b0;
                    if (!first_fall) begin
                        shft <= {shft[14:0], miso_smpl};
                    end
                end else if (div == 4'd15) begin
                    SCLK      <= 1'b1;
                    miso_smpl <= MISO;
                    rise_cnt  <= rise_cnt + 5'd1;
                end
            end
        end
    end

    assign rd_data = shft;
    assign MOSI    = ~SS_n & shft[15];

endmodule

// File: rtl/inert_intf.sv
// inert_intf: powers up and configures the inertial sensor over SPI, then reads
// pitch rate and pitch on each data-ready interrupt.
// Optional build macro: INT_TIMEOUT_EN adds an IDLE watchdog that reconfigures
// the sensor when no interrupt arrives in time.
//
// Output handshake: vld is a one-cycle strobe with no ready/backpressure; it is
// high exactly in the cycle ptch/ptch_rt first show a new sample, and the
// consumer must take the values then or later (they hold until the next vld).
module inert_intf
    import inert_pkg::*;
#(
    parameter int fast_sim = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        vld,
    output logic [15:0] ptch,
    output logic [15:0] ptch_rt
);

    inert_state_t    state, nxt_state;
    logic            int_ff1, int_ff2, int_ff3;
    logic            int_rise;
    logic [PWR_W-1:0] timer;
    logic            pwr_done;
    logic            wrt;
    logic [15:0]     wt_data;
    logic            done;
    logic [15:0]     rd_data;
    logic [7:0]      rt_lo, rt_hi, pt_lo, pt_hi;
    logic            upd;
    logic            wd_expired;
    logic            unused_rd_hi;

    SPI_mnrch u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .wt_data (wt_data),
        .MISO    (MISO),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI)
    );

    // Only the low byte of each read response carries register data.
    assign unused_rd_hi = ^rd_data[15:8];

    // Synchronise INT; third flop gives the previous value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ff1 <= 1'b0;
            int_ff2 <= 1'b0;
            int_ff3 <= 1'b0;
        end else begin
            int_ff1 <= INT;
            int_ff2 <= int_ff1;
            int_ff3 <= int_ff2;
        end
    end

    assign int_rise = int_ff2 & ~int_ff3;

    // Power-up timer counts only while waiting for the sensor to boot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timer <= '0;
        else if (state == PWR_WAIT)
            timer <= timer + 1'b1;
        else
            timer <= '0;
    end

    assign pwr_done = (fast_sim != 0) ? (&timer[PWR_W_FAST-1:0]) : (&timer);

`ifdef INT_TIMEOUT_EN
    logic [WD_W-1:0] wd_cnt;

    // Watchdog runs only in IDLE and restarts on every interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt <= '0;
        else if ((state != IDLE) || int_rise)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end

    assign wd_expired = (state == IDLE) &&
                        ((fast_sim != 0) ? (&wd_cnt[WD_W_FAST-1:0]) : (&wd_cnt));
`else
    assign wd_expired = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= PWR_WAIT;
        else
            state <= nxt_state;
    end

    // Next state; each frame is launched on the transition into its state.
    always_comb begin
        nxt_state = state;
        wrt       = 1'b0;
        wt_data   = 16'h0000;
        upd       = 1'b0;
        unique case (state)
            PWR_WAIT: if (pwr_done) begin
                nxt_state = CFG0; wrt = 1'b1; wt_data = CFG_INT;
            end
            CFG0: if (done) begin
                nxt_state = CFG1; wrt = 1'b1; wt_data = CFG_ACC;
            end
            CFG1: if (done) begin
                nxt_state = CFG2; wrt = 1'b1; wt_data = CFG_GYR;
            end
            CFG2: if (done) begin
                nxt_state = CFG3; wrt = 1'b1; wt_data = CFG_RND;
            end
            CFG3: if (done) nxt_state = IDLE;
            IDLE: begin
                if (int_rise) begin
                    nxt_state = RD0; wrt = 1'b1; wt_data = rd_cmd(RD_RTL);
                end else if (wd_expired) begin
                    nxt_state = CFG0; wrt = 1'b1; wt_data = CFG_INT;
                end
            end
            RD0: if (done) begin
                nxt_state = RD1; wrt = 1'b1; wt_data = rd_cmd(RD_RTH);
            end
            RD1: if (done) begin
                nxt_state = RD2; wrt = 1'b1; wt_data = rd_cmd(RD_PTL);
            end
            RD2: if (done) begin
                nxt_state = RD3; wrt = 1'b1; wt_data = rd_cmd(RD_PTH);
            end
            RD3: if (done) nxt_state = UPDATE;
            UPDATE: begin
                upd       = 1'b1;
                nxt_state = IDLE;
            end
            default: nxt_state = PWR_WAIT;
        endcase
    end

    // Capture each returned byte into its holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rt_lo <= 8'h00;
            rt_hi <= 8'h00;
            pt_lo <= 8'h00;
            pt_hi <= 8'h00;
        end else if (done) begin
            case (state)
                RD0:     rt_lo <= rd_data[7:0];
                RD1:     rt_hi <= rd_data[7:0];
                RD2:     pt_lo <= rd_data[7:0];
                RD3:     pt_hi <= rd_data[7:0];
                default: ;
            endcase
        end
    end

    // Publish both words together so a partial read never reaches the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptch    <= 16'h0000;
            ptch_rt <= 16'h0000;
            vld     <= 1'b0;
        end else begin
            vld <= upd;
            if (upd) begin
                ptch_rt <= {rt_hi, rt_lo};
                ptch    <= {pt_hi, pt_lo};
            end
        end
    end

endmodule

// File: tb/tb_inert_intf.sv
// Bench for inert_intf with a mode-3 SPI sensor model and scoreboards for
// MOSI frames and published samples. Optional macro: INT_TIMEOUT_EN.
module tb_inert_intf;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT   = 1'b0;
    logic        MISO  = 1'b0;
    logic        SS_n, SCLK, MOSI, vld;
    logic [15:0] ptch, ptch_rt;

    int n_checks   = 0;
    int n_fail     = 0;
    int frames_seen = 0;
    int vld_cnt    = 0;
    int stable_err = 0;

    logic [15:0] exp_q[$];      // expected MOSI frames
    logic [31:0] exp_out_q[$];  // expected {ptch_rt, ptch} per vld
    logic [7:0]  reg_mem [0:127];
    logic [15:0] last_p  = 16'h0;
    logic [15:0] last_pr = 16'h0;

    inert_intf #(.fast_sim(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .MISO    (MISO),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .vld     (vld),
        .ptch    (ptch),
        .ptch_rt (ptch_rt)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Sensor model: shifts MOSI in on SCLK rise, drives register byte on falls
    // after the command byte; frames compared against exp_q at SS_n rise.
    logic        ss_q   = 1'b1;
    logic        sclk_q = 1'b1;
    logic [15:0] rx     = 16'h0;
    int          bitn   = 0;
    logic [7:0]  tx_byte = 8'h0;

    always @(SS_n or SCLK) begin
        if (ss_q && !SS_n) begin
            rx   = 16'h0;
            bitn = 0;
            MISO = 1'b0;
        end else if (!ss_q && SS_n) begin
            if (rst_n) begin
                frames_seen++;
                check("frame_q_empty", {31'b0, exp_q.size() == 0}, 32'd0);
                if (exp_q.size() != 0)
                    check("mosi_frame", {16'h0, rx}, {16'h0, exp_q.pop_front()});
            end
        end else if (!SS_n && !sclk_q && SCLK) begin
            rx = {rx[14:0], MOSI};
            bitn++;
            if (bitn == 8) tx_byte = reg_mem[rx[6:0]];
        end else if (!SS_n && sclk_q && !SCLK) begin
            if (bitn >= 8 && bitn < 16) MISO = tx_byte[3'(15 - bitn)];
            else                        MISO = 1'b0;
        end
        ss_q   = SS_n;
        sclk_q = SCLK;
    end

    // Output monitor: compare each vld sample, and count any change without vld.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_p  = 16'h0;
            last_pr = 16'h0;
        end else if (vld) begin
            vld_cnt++;
            check("vld_q_empty", {31'b0, exp_out_q.size() == 0}, 32'd0);
            if (exp_out_q.size() != 0)
                check("ptch_out", {ptch_rt, ptch}, exp_out_q.pop_front());
            last_p  = ptch;
            last_pr = ptch_rt;
        end else if (ptch !== last_p || ptch_rt !== last_pr) begin
            stable_err++;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        int k = 0;
        while (frames_seen < target && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, frames_seen, target);
    endtask

    task automatic wait_vld(input int target, input int budget, input string tag);
        int k = 0;
        while (vld_cnt < target && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, vld_cnt, target);
    endtask

    task automatic pulse_int();
        @(negedge clk); #2;
        INT = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        INT = 1'b0;
    endtask

    task automatic push_cfg();
        exp_q.push_back(16'h0D02);
        exp_q.push_back(16'h1053);
        exp_q.push_back(16'h1150);
        exp_q.push_back(16'h1460);
    endtask

    task automatic load_sensor(input logic [7:0] rtl, input logic [7:0] rth,
                               input logic [7:0] ptl, input logic [7:0] pth);
        reg_mem[7'h22] = rtl;
        reg_mem[7'h23] = rth;
        reg_mem[7'h24] = ptl;
        reg_mem[7'h25] = pth;
    endtask

    task automatic push_reads(input int n);
        if (n > 0) exp_q.push_back(16'hA200);
        if (n > 1) exp_q.push_back(16'hA300);
        if (n > 2) exp_q.push_back(16'hA400);
        if (n > 3) exp_q.push_back(16'hA500);
    endtask

    // Release reset, measure the power-up wait, then let configuration finish.
    task automatic power_up(input string tag);
        int n = 0;
        int base_f, base_v;
        base_f = frames_seen;
        base_v = vld_cnt;
        push_cfg();
        @(negedge clk);
        rst_n = 1'b1;
        while (SS_n && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_pwr_wait_len"}, n, 1024);
        wait_frames(base_f + 4, 1400, {tag, "_cfg_frames"});
        check({tag, "_no_vld_in_cfg"}, vld_cnt, base_v);
    endtask

    task automatic run_burst(input string tag, input logic [7:0] rtl, input logic [7:0] rth,
                             input logic [7:0] ptl, input logic [7:0] pth);
        int base_f, base_v;
        load_sensor(rtl, rth, ptl, pth);
        push_reads(4);
        exp_out_q.push_back({rth, rtl, pth, ptl});
        base_f = frames_seen;
        base_v = vld_cnt;
        pulse_int();
        wait_vld(base_v + 1, 1600, {tag, "_vld"});
        check({tag, "_frames"}, frames_seen, base_f + 4);
        wait_clks(100);
    endtask

    initial begin
        int base_f, base_v;
        for (int i = 0; i < 128; i++) reg_mem[i] = 8'h00;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_SS_n",    {31'b0, SS_n}, 32'd1);
        check("rst_SCLK",    {31'b0, SCLK}, 32'd1);
        check("rst_MOSI",    {31'b0, MOSI}, 32'd0);
        check("rst_vld",     {31'b0, vld},  32'd0);
        check("rst_ptch",    {16'h0, ptch},    32'd0);
        check("rst_ptch_rt", {16'h0, ptch_rt}, 32'd0);

        power_up("boot");

        // Two ordinary bursts.
        run_burst("b1", 8'h34, 8'h12, 8'hCD, 8'hAB);
        check("b1_ptch_rt", {16'h0, ptch_rt}, 32'h1234);
        check("b1_ptch",    {16'h0, ptch},    32'hABCD);
        run_burst("b2", 8'hFF, 8'h7F, 8'h00, 8'h80);
        check("b2_ptch_rt", {16'h0, ptch_rt}, 32'h7FFF);
        check("b2_ptch",    {16'h0, ptch},    32'h8000);
        check("stable_b1_b2", stable_err, 0);

        // INT pulsed again during RD1 must be dropped.
        load_sensor(8'h11, 8'h22, 8'h33, 8'h44);
        push_reads(4);
        exp_out_q.push_back(32'h2211_4433);
        base_f = frames_seen;
        base_v = vld_cnt;
        pulse_int();
        wait_frames(base_f + 1, 600, "drop_rd0_done");
        wait_clks(50);
        pulse_int();
        wait_vld(base_v + 1, 1600, "drop_vld");
        wait_clks(400);
        check("drop_frames", frames_seen, base_f + 4);
        check("drop_vld_once", vld_cnt, base_v + 1);

        run_burst("b4", 8'h01, 8'h02, 8'h03, 8'h04);

        // Reset in the middle of RD2.
        load_sensor(8'h55, 8'h66, 8'h77, 8'h88);
        push_reads(2);
        base_f = frames_seen;
        pulse_int();
        wait_frames(base_f + 2, 1000, "rst_mid_rd01");
        wait_clks(100);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_SS_n",    {31'b0, SS_n}, 32'd1);
        check("midrst_vld",     {31'b0, vld},  32'd0);
        check("midrst_ptch",    {16'h0, ptch},    32'd0);
        check("midrst_ptch_rt", {16'h0, ptch_rt}, 32'd0);
        repeat (3) @(posedge clk);
        power_up("reboot");
        run_burst("b5", 8'h9A, 8'h78, 8'hDE, 8'hBC);

`ifdef INT_TIMEOUT_EN
        // No INT: watchdog resends configuration, outputs hold.
        push_cfg();
        base_f = frames_seen;
        base_v = vld_cnt;
        wait_frames(base_f + 4, 3800, "wd_cfg_frames");
        check("wd_no_vld", vld_cnt, base_v);
`else
        // No INT: IDLE waits forever.
        base_f = frames_seen;
        base_v = vld_cnt;
        wait_clks(3500);
        check("idle_no_frames", frames_seen, base_f);
        check("idle_no_vld", vld_cnt, base_v);
`endif
        check("hold_ptch_rt", {16'h0, ptch_rt}, 32'h789A);
        check("hold_ptch",    {16'h0, ptch},    32'hBCDE);
        check("stable_all", stable_err, 0);
        check("exp_q_drained", exp_q.size(), 0);
        check("exp_out_drained", exp_out_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
